// File: rtl/tt_sweep_checker.sv
// Truth-table sweeper for 3-input combinational functions: drives {S,M,W} = 0..7, samples f_in
// after a settle interval, and compares the captured table with EXPECTED. Optional error
// statistics (err_cnt, first_fail) are compiled in with `define TT_SWEEP_ERRCNT_EN.
module tt_sweep_checker #(
    parameter int          SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = 8'hD0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       f_in,
    output logic       drv_s,
    output logic       drv_m,
    output logic       drv_w,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_q,
    output logic       match
`ifdef TT_SWEEP_ERRCNT_EN
    ,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail
`endif
);

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] idx_reg, idx_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] table_reg, table_next;
    logic       match_reg, match_next;
    logic       done_reg, done_next;

    // Table as it will look once the current vector's sample is folded in.
    logic [7:0] sampled_table;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sample
            assign sampled_table[gi] = (idx_reg == 3'(gi)) ? f_in : table_reg[gi];
        end
    endgenerate

`ifdef TT_SWEEP_ERRCNT_EN
    logic [7:0] mismatch;
    logic [3:0] err_cnt_reg, err_cnt_next, err_cnt_calc;
    logic [2:0] first_fail_reg, first_fail_next, first_fail_calc;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_mismatch
            assign mismatch[gi] = sampled_table[gi] ^ EXPECTED[gi];
        end
    endgenerate

    always_comb begin
        err_cnt_calc    = 4'd0;
        first_fail_calc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            err_cnt_calc = err_cnt_calc + {3'b000, mismatch[i]};
        end
        // Scan downward so the lowest failing index wins; stays 0 on a pass.
        for (int i = 7; i >= 0; i--) begin
            if (mismatch[i]) begin
                first_fail_calc = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        table_next = table_reg;
        match_next = match_reg;
        done_next  = 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
        err_cnt_next    = err_cnt_reg;
        first_fail_next = first_fail_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = HOLD;
                    idx_next   = 3'd0;
                    cnt_next   = RELOAD;
                    table_next = 8'h00;
                    match_next = 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
                    err_cnt_next    = 4'd0;
                    first_fail_next = 3'd0;
`endif
                end
            end
            HOLD: begin
                if (cnt_reg == 4'd0) begin
                    table_next = sampled_table;
                    if (idx_reg == 3'd7) begin
                        state_next = IDLE;
                        idx_next   = 3'd0;
                        done_next  = 1'b1;
                        match_next = (sampled_table == EXPECTED);
`ifdef TT_SWEEP_ERRCNT_EN
                        err_cnt_next    = err_cnt_calc;
                        first_fail_next = first_fail_calc;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        cnt_next = RELOAD;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= 4'd0;
            table_reg <= 8'h00;
            match_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            table_reg <= table_next;
            match_reg <= match_next;
            done_reg  <= done_next;
        end
    end

`ifdef TT_SWEEP_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_reg    <= 4'd0;
            first_fail_reg <= 3'd0;
        end else begin
            err_cnt_reg    <= err_cnt_next;
            first_fail_reg <= first_fail_next;
        end
    end

    assign err_cnt    = err_cnt_reg;
    assign first_fail = first_fail_reg;
`endif

    assign busy                  = (state_reg == HOLD);
    assign {drv_s, drv_m, drv_w} = (state_reg == HOLD) ? idx_reg : 3'b000;
    assign done                  = done_reg;
    assign table_q               = table_reg;
    assign match                 = match_reg;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: the function under test is a truth table indexed by the DUT's own
// drive lines; expected tables, match and error statistics come from plain per-vector arithmetic.
module tb_tt_sweep_checker;

    localparam logic [7:0] EXP = 8'hD0;
    localparam int         SA  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DUT A: SETTLE=2
    logic       start_a = 1'b0;
    logic [7:0] fn_a = 8'h00;
    logic       f_a, drv_s_a, drv_m_a, drv_w_a, busy_a, done_a, match_a;
    logic [7:0] table_a;
    // DUT B: SETTLE=1
    logic       start_b = 1'b0;
    logic [7:0] fn_b = 8'h00;
    logic       f_b, drv_s_b, drv_m_b, drv_w_b, busy_b, done_b, match_b;
    logic [7:0] table_b;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [3:0] err_cnt_a, err_cnt_b;
    logic [2:0] first_fail_a, first_fail_b;
`endif

    assign f_a = fn_a[{drv_s_a, drv_m_a, drv_w_a}];
    assign f_b = fn_b[{drv_s_b, drv_m_b, drv_w_b}];

    tt_sweep_checker #(.SETTLE(2), .EXPECTED(EXP)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .f_in(f_a),
        .drv_s(drv_s_a), .drv_m(drv_m_a), .drv_w(drv_w_a),
        .busy(busy_a), .done(done_a), .table_q(table_a), .match(match_a)
`ifdef TT_SWEEP_ERRCNT_EN
        , .err_cnt(err_cnt_a), .first_fail(first_fail_a)
`endif
    );

    tt_sweep_checker #(.SETTLE(1), .EXPECTED(EXP)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .f_in(f_b),
        .drv_s(drv_s_b), .drv_m(drv_m_b), .drv_w(drv_w_b),
        .busy(busy_b), .done(done_b), .table_q(table_b), .match(match_b)
`ifdef TT_SWEEP_ERRCNT_EN
        , .err_cnt(err_cnt_b), .first_fail(first_fail_b)
`endif
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truth table of a named lab equation, evaluated vector by vector.
    function automatic logic [7:0] eq_table(input int which);
        logic [7:0] t;
        logic s, m, w;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            s = (i / 4) % 2 == 1;
            m = (i / 2) % 2 == 1;
            w = i % 2 == 1;
            case (which)
                0:       t[i] = s & (~w | m);
                1:       t[i] = (s & ~m & ~w) | (s & m & w);
                default: t[i] = 1'b0;
            endcase
        end
        return t;
    endfunction

    function automatic int ref_errs(input logic [7:0] t);
        int n = 0;
        for (int i = 0; i < 8; i++) if (t[i] != EXP[i]) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [7:0] t);
        for (int i = 0; i < 8; i++) if (t[i] != EXP[i]) return i;
        return 0;
    endfunction

    // One sweep on DUT A; optionally re-asserts start during vector 3 or resets during reset_idx.
    task automatic sweep_a(input logic [7:0] fn, input bit mid_start, input int reset_idx);
        int         idx;
        logic [7:0] mask;
        @(negedge clk);
        fn_a    = fn;
        start_a = 1'b1;
        for (int j = 0; j < 8 * SA; j++) begin
            @(negedge clk);
            idx     = j / SA;
            start_a = mid_start && (idx == 3);
            mask    = 8'((1 << idx) - 1);
            chk_b("a_busy", busy_a, 1'b1);
            chk_v("a_drv", {5'b0, drv_s_a, drv_m_a, drv_w_a}, 8'(idx));
            chk_b("a_done_low", done_a, 1'b0);
            chk_v("a_table_partial", table_a, fn & mask);
            chk_b("a_match_cleared", match_a, 1'b0);
            if (idx == reset_idx) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_b("rst_busy", busy_a, 1'b0);
                chk_v("rst_drv", {5'b0, drv_s_a, drv_m_a, drv_w_a}, 8'h00);
                chk_v("rst_table", table_a, 8'h00);
                chk_b("rst_match", match_a, 1'b0);
                repeat (8 * SA + 2) begin
                    @(negedge clk);
                    chk_b("rst_no_done", done_a, 1'b0);
                    chk_b("rst_idle", busy_a, 1'b0);
                end
                $display("sweep A fn=%02h reset at idx=%0d", fn, reset_idx);
                return;
            end
        end
        @(negedge clk);
        chk_b("a_done", done_a, 1'b1);
        chk_b("a_busy_end", busy_a, 1'b0);
        chk_v("a_drv_end", {5'b0, drv_s_a, drv_m_a, drv_w_a}, 8'h00);
        chk_v("a_table", table_a, fn);
        chk_b("a_match", match_a, fn == EXP);
`ifdef TT_SWEEP_ERRCNT_EN
        chk_v("a_err_cnt", {4'b0, err_cnt_a}, 8'(ref_errs(fn)));
        chk_v("a_first_fail", {5'b0, first_fail_a}, 8'(ref_first(fn)));
`endif
        @(negedge clk);
        chk_b("a_done_pulse", done_a, 1'b0);
        chk_v("a_table_hold", table_a, fn);
        chk_b("a_match_hold", match_a, fn == EXP);
        $display("sweep A fn=%02h table=%02h match=%b", fn, table_a, match_a);
    endtask

    initial begin
        logic [7:0] cur_fn;
        int         ph;

        repeat (3) @(negedge clk);
        chk_b("reset_busy", busy_a, 1'b0);
        chk_b("reset_done", done_a, 1'b0);
        chk_v("reset_table", table_a, 8'h00);
        chk_b("reset_match", match_a, 1'b0);
        chk_v("reset_drv", {5'b0, drv_s_a, drv_m_a, drv_w_a}, 8'h00);
        chk_b("reset_busy_b", busy_b, 1'b0);
        chk_v("reset_table_b", table_b, 8'h00);
`ifdef TT_SWEEP_ERRCNT_EN
        chk_v("reset_err_cnt", {4'b0, err_cnt_a}, 8'h00);
        chk_v("reset_first_fail", {5'b0, first_fail_a}, 8'h00);
`endif
        reset = 1'b0;

        sweep_a(eq_table(0), 1'b0, -1);
        sweep_a(eq_table(2), 1'b0, -1);
        sweep_a(eq_table(1), 1'b0, -1);
        repeat (3) sweep_a(8'($urandom), 1'b0, -1);
        sweep_a(eq_table(0), 1'b1, -1);
        sweep_a(8'($urandom), 1'b0, 5);
        sweep_a(eq_table(0), 1'b0, -1);

        // Back-to-back sweeps on the SETTLE=1 instance with start held high.
        @(negedge clk);
        cur_fn  = 8'($urandom);
        fn_b    = cur_fn;
        start_b = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            ph = c % 9;
            if (ph == 8) begin
                chk_b("b_done", done_b, 1'b1);
                chk_b("b_busy_gap", busy_b, 1'b0);
                chk_v("b_drv_gap", {5'b0, drv_s_b, drv_m_b, drv_w_b}, 8'h00);
                chk_v("b_table", table_b, cur_fn);
                chk_b("b_match", match_b, cur_fn == EXP);
`ifdef TT_SWEEP_ERRCNT_EN
                chk_v("b_err_cnt", {4'b0, err_cnt_b}, 8'(ref_errs(cur_fn)));
                chk_v("b_first_fail", {5'b0, first_fail_b}, 8'(ref_first(cur_fn)));
`endif
                $display("sweep B fn=%02h table=%02h match=%b", cur_fn, table_b, match_b);
                cur_fn = (c == 17) ? EXP : 8'($urandom);
                fn_b   = cur_fn;
            end else begin
                chk_b("b_done_low", done_b, 1'b0);
                chk_b("b_busy", busy_b, 1'b1);
                chk_v("b_drv", {5'b0, drv_s_b, drv_m_b, drv_w_b}, 8'(ph));
                chk_v("b_table_partial", table_b, cur_fn & 8'((1 << ph) - 1));
                chk_b("b_match_cleared", match_b, 1'b0);
            end
        end
        start_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
